// File: rtl/chunked_adder_if.sv
// Valid/ready operand and result bundle for chunked_adder.
// The master drives operands and consumes results; the slave is the adder.
interface chunked_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/chunked_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, carry held between
// digits, signed overflow taken from the carries around the MSB.
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx_q;
    logic             last;

    logic [DIGIT-1:0] a_k;
    logic [DIGIT-1:0] b_k;
    logic [DIGIT-1:0] d_k;
    logic             c_k;
    logic             msb_cin;

    assign last = (idx_q == IW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, N digit cycles, hold until consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state flop or taken straight from registers.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.sum       = sum_q;
        bus.carry_out = cout_q;
        bus.overflow  = ovf_q;
    end

    // One digit of the ripple: the carry into the digit MSB is recovered
    // from its sum bit, so no separate narrow adder is needed for overflow.
    always_comb begin
        a_k = a_q[int'(idx_q)*DIGIT +: DIGIT];
        b_k = b_q[int'(idx_q)*DIGIT +: DIGIT];
        {c_k, d_k} = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, carry_q};
        msb_cin = a_k[DIGIT-1] ^ b_k[DIGIT-1] ^ d_k[DIGIT-1];
    end

    // Operand capture and digit-serial accumulation of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ^ bus.carry_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*DIGIT +: DIGIT] <= d_k;
                    carry_q <= c_k;
                    if (last) begin
                        cout_q <= c_k;
                        ovf_q  <= msb_cin ^ c_k;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule
